// File: rtl/ste_joy_pkg.sv
// Shared constants and line-composition helper for the STE joystick scan stage.
// Bit layout of a port is {fire,right,left,down,up}; all CPU-visible lines are active low.
package ste_joy_pkg;

    localparam int JOY_UP    = 0;
    localparam int JOY_DOWN  = 1;
    localparam int JOY_LEFT  = 2;
    localparam int JOY_RIGHT = 3;
    localparam int JOY_FIRE  = 4;

    localparam int SEL_PORT_A = 0;
    localparam int SEL_PORT_B = 1;

    localparam int PORT_BITS = 5;

    localparam logic [15:0] WORD_IDLE = 16'hFFFF;
    localparam logic [3:0]  SEL_IDLE  = 4'hF;

    // Returns {fire_n, right_n, left_n, down_n, up_n}; a deselected column floats high.
    function automatic logic [PORT_BITS-1:0] port_lines(
        input logic [PORT_BITS-1:0] deb,
        input logic                 col_n
    );
        logic [PORT_BITS-1:0] lines;
        lines = ~{deb[JOY_FIRE], deb[JOY_RIGHT], deb[JOY_LEFT], deb[JOY_DOWN], deb[JOY_UP]};
        return col_n ? {PORT_BITS{1'b1}} : lines;
    endfunction

endpackage

// File: rtl/joy_debounce.sv
// One joystick line: two-flop synchroniser followed by a tick-sampled history
// that only lets the debounced level move once DEB_SAMPLES samples agree.
module joy_debounce #(
    parameter int DEB_SAMPLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic level
);

    logic                   meta;
    logic                   sync;
    // Only the older DEB_SAMPLES-1 samples are stored; the newest is the live sync bit.
    logic [DEB_SAMPLES-2:0] hist;
    logic [DEB_SAMPLES-1:0] hist_next;

    always_comb begin
        hist_next = {hist, sync};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the synchroniser and history are reset as well, so a button
            // held through reset has to re-qualify from scratch.
            meta  <= 1'b0;
            sync  <= 1'b0;
            hist  <= '0;
            level <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (tick) begin
                hist <= hist_next[DEB_SAMPLES-2:0];
                if (&hist_next) begin
                    level <= 1'b1;
                end else if (~|hist_next) begin
                    level <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/ste_joy_scan.sv
// STE joystick conditioning stage: debounces ports A/B, holds the column select
// and registers the active-low fire/direction words plus a one-cycle change strobe.
module ste_joy_scan
    import ste_joy_pkg::*;
#(
    parameter logic [15:0] TICK_DIV    = 16'd32000,
    parameter int          DEB_SAMPLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  joy_a,
    input  logic [4:0]  joy_b,
    input  logic        sel_we,
    input  logic [3:0]  sel_din,
    output logic [15:0] fire_word,
    output logic [15:0] dir_word,
    output logic        changed
);

    logic [15:0]              presc;
    logic                     tick;
    logic [2*PORT_BITS-1:0]   raw_bits;
    logic [2*PORT_BITS-1:0]   deb_bits;
    logic [3:0]               sel;
    logic [PORT_BITS-1:0]     lines_a;
    logic [PORT_BITS-1:0]     lines_b;
    logic [15:0]              fire_next;
    logic [15:0]              dir_next;
    logic                     unused_reserved;

    assign tick = (presc == TICK_DIV - 16'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 16'd1;
        end
    end

    assign raw_bits = {joy_b, joy_a};

    for (genvar i = 0; i < 2 * PORT_BITS; i++) begin : g_bit
        joy_debounce #(
            .DEB_SAMPLES(DEB_SAMPLES)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .tick (tick),
            .raw  (raw_bits[i]),
            .level(deb_bits[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel <= SEL_IDLE;
        end else if (sel_we) begin
            sel <= sel_din;
        end
    end

    // Reserved columns have no joystick behind them and never pull a line low.
    assign unused_reserved = ^sel[3:2];

    // NOTE: every always_comb output is given a default first, so no path can
    // leave a bit unassigned and infer a latch.
    always_comb begin
        fire_next    = WORD_IDLE;
        dir_next     = WORD_IDLE;
        lines_a      = port_lines(deb_bits[PORT_BITS-1:0], sel[SEL_PORT_A]);
        lines_b      = port_lines(deb_bits[2*PORT_BITS-1:PORT_BITS], sel[SEL_PORT_B]);
        dir_next[3:0] = lines_a[3:0];
        dir_next[7:4] = lines_b[3:0];
        fire_next[0]  = lines_a[JOY_FIRE];
        fire_next[1]  = lines_b[JOY_FIRE];
    end

    // The strobe compares against the currently held words, so rewriting an
    // identical select value or a steady input never pulses it.
    always_ff @(posedge clk) begin
        if (reset) begin
            fire_word <= WORD_IDLE;
            dir_word  <= WORD_IDLE;
            changed   <= 1'b0;
        end else begin
            fire_word <= fire_next;
            dir_word  <= dir_next;
            changed   <= (fire_next != fire_word) || (dir_next != dir_word);
        end
    end

endmodule

// File: tb/tb_ste_joy_scan.sv
// Directed bench for ste_joy_scan with a scoreboard: stimulus pushes the expected
// output words, a monitor pops and compares one entry per changed pulse.
module tb_ste_joy_scan;

    localparam logic [15:0] TICK_DIV    = 16'd4;
    localparam int          DEB_SAMPLES = 3;

    typedef struct {
        logic [15:0] fire;
        logic [15:0] dir;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [4:0]  joy_a;
    logic [4:0]  joy_b;
    logic        sel_we;
    logic [3:0]  sel_din;
    logic [15:0] fire_word;
    logic [15:0] dir_word;
    logic        changed;

    exp_t        exp_q[$];
    int          n_pass;
    int          n_total;
    logic [15:0] tb_presc;

    ste_joy_scan #(
        .TICK_DIV   (TICK_DIV),
        .DEB_SAMPLES(DEB_SAMPLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .joy_a    (joy_a),
        .joy_b    (joy_b),
        .sel_we   (sel_we),
        .sel_din  (sel_din),
        .fire_word(fire_word),
        .dir_word (dir_word),
        .changed  (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent model of the sample-tick phase, used to time the simultaneous case.
    always @(posedge clk) begin
        if (reset) tb_presc <= 16'd0;
        else if (tb_presc == TICK_DIV - 16'd1) tb_presc <= 16'd0;
        else tb_presc <= tb_presc + 16'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    endtask

    task automatic push(input logic [15:0] f, input logic [15:0] d);
        exp_t e;
        e.fire = f;
        e.dir  = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every changed pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (changed === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected changed", {31'd0, changed}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb fire_word", {16'd0, fire_word}, {16'd0, e.fire});
                check("sb dir_word", {16'd0, dir_word}, {16'd0, e.dir});
            end
        end
    end

    task automatic wait_drain(input string name, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_sel(input logic [3:0] v);
        sel_we  = 1'b1;
        sel_din = v;
        @(negedge clk);
        sel_we  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        joy_a   = 5'd0;
        joy_b   = 5'd0;
        sel_we  = 1'b0;
        sel_din = 4'hF;

        // Reset state, then ten quiet cycles.
        idle(3);
        check("reset fire_word", {16'd0, fire_word}, 32'h0000_FFFF);
        check("reset dir_word", {16'd0, dir_word}, 32'h0000_FFFF);
        check("reset changed", {31'd0, changed}, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle fire_word", {16'd0, fire_word}, 32'h0000_FFFF);
            check("idle dir_word", {16'd0, dir_word}, 32'h0000_FFFF);
            check("idle changed", {31'd0, changed}, 32'd0);
        end

        // Qualified press and release of port A up.
        write_sel(4'hE);
        joy_a = 5'b00001;
        push(16'hFFFF, 16'hFFFE);
        wait_drain("press up latency", 15);
        idle(10);
        check("held up dir_word", {16'd0, dir_word}, 32'h0000_FFFE);
        joy_a = 5'b00000;
        push(16'hFFFF, 16'hFFFF);
        wait_drain("release up latency", 15);

        // Select gating of a debounced port B fire+left.
        write_sel(4'hF);
        joy_b = 5'b10100;
        idle(20);
        check("gated fire_word", {16'd0, fire_word}, 32'h0000_FFFF);
        check("gated dir_word", {16'd0, dir_word}, 32'h0000_FFFF);
        sel_we  = 1'b1;
        sel_din = 4'hD;
        push(16'hFFFD, 16'hFFBF);
        @(negedge clk);
        sel_we = 1'b0;
        check("select not yet visible", {16'd0, dir_word}, 32'h0000_FFFF);
        wait_drain("select one-cycle latency", 1);
        write_sel(4'hD);
        idle(3);
        joy_b = 5'b00000;
        push(16'hFFFF, 16'hFFFF);
        wait_drain("release port B", 15);

        // Bounce shorter than the qualification window never reaches the outputs.
        write_sel(4'hE);
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) joy_a[0] = ~joy_a[0];
            @(negedge clk);
        end
        joy_a = 5'b00000;
        idle(20);
        check("bounce dir_word", {16'd0, dir_word}, 32'h0000_FFFF);

        // Select write lands in the exact cycle port A right qualifies.
        joy_b = 5'b00010;
        idle(20);
        check("B down gated", {16'd0, dir_word}, 32'h0000_FFFF);
        for (int k = 0; k < 8 && tb_presc != 16'd0; k++) @(negedge clk);
        joy_a = 5'b01000;
        push(16'hFFFF, 16'hFFD7);
        idle(11);
        sel_we  = 1'b1;
        sel_din = 4'hC;
        @(negedge clk);
        sel_we = 1'b0;
        check("simultaneous not early", {16'd0, dir_word}, 32'h0000_FFFF);
        wait_drain("simultaneous single update", 1);
        idle(5);
        joy_a = 5'b00000;
        joy_b = 5'b00000;
        push(16'hFFFF, 16'hFFFF);
        wait_drain("release simultaneous", 15);

        // Reset mid-operation with port A fire held.
        write_sel(4'hE);
        joy_a = 5'b10000;
        push(16'hFFFE, 16'hFFFF);
        wait_drain("fire A qualify", 15);
        idle(3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid reset fire_word", {16'd0, fire_word}, 32'h0000_FFFF);
        check("mid reset dir_word", {16'd0, dir_word}, 32'h0000_FFFF);
        check("mid reset changed", {31'd0, changed}, 32'd0);
        sel_we  = 1'b1;
        sel_din = 4'hE;
        push(16'hFFFE, 16'hFFFF);
        @(negedge clk);
        sel_we = 1'b0;
        idle(11);
        check("requalify not early", {16'd0, fire_word}, 32'h0000_FFFF);
        wait_drain("requalify after reset", 1);

        idle(5);
        check("scoreboard empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ste_joy_scan.md
Name: ste_joy_scan

Overview:
- Upstream conditioning stage for the STE joystick register block.
- Takes raw digital joystick states for ports A and B from the IO controller, synchronises and debounces them, and holds the CPU-written column-select nibble.
- Produces the registered active-low fire and direction words that the register block returns on CPU reads.
- Adds a one-cycle change strobe for optional interrupt or monitor use.

Parameters:
- TICK_DIV, 16'd32000, clk cycles per debounce sample tick (1 ms at 32 MHz); legal range 2..65535.
- DEB_SAMPLES, 3, consecutive equal sample ticks required before a debounced bit changes; legal range 2..8.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- joy_a  in  5  port A raw {fire,right,left,down,up}, active-high pressed, asynchronous to clk.
- joy_b  in  5  port B raw, same layout.
- sel_we  in  1  one-cycle strobe from the register block on a CPU write to the select register.
- sel_din  in  4  select nibble, active low; bit0 = port A, bit1 = port B, bits 3:2 = reserved columns.
- fire_word  out  16  active-low fire lines for the fire register.
- dir_word  out  16  active-low direction lines for the direction register.
- changed  out  1  one-cycle pulse when fire_word or dir_word changes value.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high; all state updates on posedge clk.
- Reset values:
  - fire_word = 16'hFFFF, dir_word = 16'hFFFF, changed = 0.
  - Select latch = 4'hF.
  - Prescaler = 0.
  - All synchroniser flops, sample histories and debounced bits = 0 (released).
- Synchroniser: each of the 10 raw bits passes through a 2-flop synchroniser before anything else uses it.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick is high for one cycle when the count equals TICK_DIV-1.
- Debounce (per bit):
  - On tick, shift the synchronised value into a DEB_SAMPLES-deep history.
  - When the whole history holds the same value, the debounced bit takes that value in the same cycle as the tick.
  - A mixed history leaves the debounced bit unchanged.
  - Worst-case press latency is 2 + DEB_SAMPLES*TICK_DIV cycles.
- Select latch: sel_din is captured on the cycle sel_we is high. The new value drives the outputs on the next cycle's output update.
- Output composition (combinational next value, registered):
  - dir_word[3:0] = ~{right,left,down,up}_A if sel[0]==0, else 4'hF.
  - dir_word[7:4] = ~{right,left,down,up}_B if sel[1]==0, else 4'hF.
  - dir_word[15:8] = 8'hFF.
  - fire_word[0] = ~fire_A if sel[0]==0, else 1.
  - fire_word[1] = ~fire_B if sel[1]==0, else 1.
  - fire_word[15:2] = all ones.
  - Reserved columns sel[3:2] never pull any line low.
- Output latency: outputs register one cycle after a debounced-bit change or a select latch update.
- changed: high for exactly one cycle in the cycle the output registers take a value different from their previous value. It is never asserted in the reset cycle or the first cycle after reset.
- Simultaneous events:
  - sel_we in the same cycle as a debounce update: both take effect, and the outputs reflect both one cycle later.
  - Repeated sel_we with an identical value produces no changed pulse.
- Reset mid-operation:
  - Histories, debounced bits and select are cleared, so a held button must re-qualify for DEB_SAMPLES ticks.
  - Outputs return to FFFF in the cycle after reset is sampled.
- Bounce: a raw glitch shorter than one tick period that is not captured in DEB_SAMPLES consecutive ticks never reaches the outputs.

Decomposition:
- Package ste_joy_pkg:
  - Bit-index constants JOY_UP=0, JOY_DOWN=1, JOY_LEFT=2, JOY_RIGHT=3, JOY_FIRE=4.
  - SEL_PORT_A=0, SEL_PORT_B=1.
  - Reset constants WORD_IDLE=16'hFFFF and SEL_IDLE=4'hF.
- Sub-module joy_debounce:
  - One bit: synchroniser, history and debounced output.
  - Parameter DEB_SAMPLES; inputs clk, reset, tick, raw.
  - Instantiated 10 times.
  - Prescaler and output composition stay in the top module.

Test Plan:
- Reset state: hold reset 3 cycles -> fire_word=16'hFFFF, dir_word=16'hFFFF, changed=0; the same values hold for 10 cycles after release with no input activity.
- Qualified press: TICK_DIV=4, DEB_SAMPLES=3; sel_din=4'hE with sel_we; hold joy_a=5'b00001 (up) -> dir_word=16'hFFFE within 2+12+1 cycles; changed pulses exactly once; release -> dir_word returns to 16'hFFFF with one further pulse.
- Select gating: joy_b fire and left held and debounced, select 4'hF -> fire_word=16'hFFFF, dir_word=16'hFFFF; write 4'hD -> one cycle later fire_word=16'hFFFD, dir_word=16'hFFBF, one changed pulse.
- Bounce rejection: toggle joy_a[0] every 3 cycles for 40 cycles with TICK_DIV=4 -> dir_word stays 16'hFFFF and changed never asserts.
- Simultaneous events: sel_we (4'hC) in the exact cycle a port A right press qualifies, port B down already debounced -> next cycle dir_word=16'hFFD7, single changed pulse.
- Reset mid-operation: with port A fire qualified and select 4'hE, assert reset 1 cycle -> fire_word=16'hFFFF next cycle; with the button still held and sel rewritten to 4'hE, fire_word=16'hFFFE only after DEB_SAMPLES ticks.
